// File: rtl/load_store_unit.sv
// RV32I load/store unit: bridges ALU effective addresses to a word-wide memory req/gnt/rvalid bus.
// Latency (zero-wait memory): error completes 1 cycle after accept, store 2, load 3; outputs registered.
// Backpressure: in_ready is low whenever the unit is busy; mem_req and its payload hold until mem_gnt.
module load_store_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  in_opcode,
   input  logic [2:0]  in_funct3,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [4:0]  in_rd,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   output logic        out_we,
   output logic [4:0]  out_rd,
   output logic [31:0] out_data,
   output logic [1:0]  out_err
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

   state_t         state, state_nxt;
   logic           is_load;
   logic [2:0]     funct3;
   logic [1:0]     byte_off;
   logic [CW-1:0]  cnt;

   logic           accept, in_is_load, in_is_store;
   logic           dec_err;
   logic [3:0]     dec_wstrb;
   logic [31:0]    dec_wdata;
   logic [31:0]    shifted, load_data;
   logic           gnt_ev, rv_ev, tmo;

   assign in_ready    = (state == IDLE);
   assign accept      = in_valid & in_ready;
   assign in_is_load  = (in_opcode == OP_LOAD);
   assign in_is_store = (in_opcode == OP_STORE);
   assign gnt_ev      = (state == REQ) & mem_gnt;
   assign rv_ev       = (state == RESP) & mem_rvalid;
   // Grant/rvalid in the limit cycle wins over the timeout.
   assign tmo         = (TIMEOUT != 0) & (cnt == LIMIT) &
                        (((state == REQ) & ~mem_gnt) | ((state == RESP) & ~mem_rvalid));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decision
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = dec_err ? DONE : REQ;
         REQ:  if (gnt_ev) state_nxt = is_load ? RESP : DONE;
               else if (tmo) state_nxt = DONE;
         RESP: if (rv_ev || tmo) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Decode incoming op: legality, alignment, store byte lanes and replicated data
   always_comb begin
      dec_err   = 1'b0;
      dec_wstrb = 4'b0000;
      dec_wdata = 32'h0;
      if (in_is_load) begin
         case (in_funct3)
            3'b000, 3'b100: dec_err = 1'b0;
            3'b001, 3'b101: dec_err = in_addr[0];
            3'b010:         dec_err = (in_addr[1:0] != 2'b00);
            default:        dec_err = 1'b1;
         endcase
      end else if (in_is_store) begin
         case (in_funct3)
            3'b000: begin
               dec_wstrb = 4'b0001 << in_addr[1:0];
               dec_wdata = {4{in_wdata[7:0]}};
            end
            3'b001: begin
               dec_err   = in_addr[0];
               dec_wstrb = 4'b0011 << in_addr[1:0];
               dec_wdata = {2{in_wdata[15:0]}};
            end
            3'b010: begin
               dec_err   = (in_addr[1:0] != 2'b00);
               dec_wstrb = 4'b1111;
               dec_wdata = in_wdata;
            end
            default: dec_err = 1'b1;
         endcase
      end else begin
         dec_err = 1'b1;
      end
   end

   // Extract the addressed byte/half from the read word and extend it
   always_comb begin
      shifted = mem_rdata >> {byte_off, 3'b000};
      case (funct3)
         3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  load_data = {24'h0, shifted[7:0]};
         3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  load_data = {16'h0, shifted[15:0]};
         default: load_data = mem_rdata;
      endcase
   end

   // Registered bus outputs, completion outputs and the wait counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_load   <= 1'b0;
         funct3    <= 3'b000;
         byte_off  <= 2'b00;
         cnt       <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wstrb <= 4'b0000;
         mem_wdata <= 32'h0;
         out_valid <= 1'b0;
         out_we    <= 1'b0;
         out_rd    <= 5'd0;
         out_data  <= 32'h0;
         out_err   <= 2'b00;
      end else begin
         out_valid <= 1'b0;
         out_we    <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               is_load  <= in_is_load;
               funct3   <= in_funct3;
               byte_off <= in_addr[1:0];
               out_rd   <= in_rd;
               cnt      <= '0;
               if (dec_err) begin
                  out_valid <= 1'b1;
                  out_err   <= 2'b01;
                  out_data  <= 32'h0;
               end else begin
                  mem_req   <= 1'b1;
                  mem_we    <= in_is_store;
                  mem_addr  <= {in_addr[31:2], 2'b00};
                  mem_wstrb <= dec_wstrb;
                  mem_wdata <= dec_wdata;
               end
            end
            REQ: begin
               cnt <= cnt + 1'b1;
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  cnt     <= '0;
                  if (!is_load) begin
                     out_valid <= 1'b1;
                     out_err   <= 2'b00;
                     out_data  <= 32'h0;
                  end
               end else if (tmo) begin
                  mem_req   <= 1'b0;
                  out_valid <= 1'b1;
                  out_err   <= 2'b10;
                  out_data  <= 32'h0;
               end
            end
            RESP: begin
               cnt <= cnt + 1'b1;
               if (mem_rvalid) begin
                  out_valid <= 1'b1;
                  out_we    <= 1'b1;
                  out_err   <= 2'b00;
                  out_data  <= load_data;
               end else if (tmo) begin
                  out_valid <= 1'b1;
                  out_err   <= 2'b10;
                  out_data  <= 32'h0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table with a responsive memory, plus timeout,
// wait-state and mid-operation reset sequences. DUT built with TIMEOUT=4.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic [31:0] in_addr, in_wdata;
   logic [4:0]  in_rd;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        out_valid, out_we;
   logic [4:0]  out_rd;
   logic [31:0] out_data;
   logic [1:0]  out_err;

   int total = 0;
   int bad   = 0;

   localparam logic [6:0] LD = 7'b0000011;
   localparam logic [6:0] ST = 7'b0100011;

   load_store_unit #(.TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_funct3(in_funct3),
      .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_we(out_we), .out_rd(out_rd), .out_data(out_data), .out_err(out_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] rdata;
      logic        e_req;
      logic [3:0]  e_wstrb;
      logic [31:0] e_wdata;
      logic [31:0] e_data;
      logic [1:0]  e_err;
      logic        e_we;
      int          e_lat;
   } vec_t;

   localparam int NV = 17;
   vec_t vec [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rd);
      in_valid  = 1'b1;
      in_opcode = op;
      in_funct3 = f3;
      in_addr   = addr;
      in_wdata  = wd;
      in_rd     = rd;
      tick();
      in_valid  = 1'b0;
   endtask

   initial begin
      //         op  f3      addr          wdata         rd     rdata         req wstrb    e_wdata       e_data        err    we   lat
      vec[0]  = '{ST, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 5'd1,  32'h0,         1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0,         2'b00, 1'b0, 2};
      vec[1]  = '{ST, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd2,  32'h0,         1'b1, 4'b1000, 32'hA5A5_A5A5, 32'h0,         2'b00, 1'b0, 2};
      vec[2]  = '{ST, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 5'd3,  32'h0,         1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0,         2'b00, 1'b0, 2};
      vec[3]  = '{ST, 3'b000, 32'h0000_1001, 32'h0000_00C3, 5'd4,  32'h0,         1'b1, 4'b0010, 32'hC3C3_C3C3, 32'h0,         2'b00, 1'b0, 2};
      vec[4]  = '{LD, 3'b000, 32'h0000_2002, 32'h0,         5'd5,  32'h1280_FF00, 1'b1, 4'b0000, 32'h0,         32'hFFFF_FF80, 2'b00, 1'b1, 3};
      vec[5]  = '{LD, 3'b100, 32'h0000_2002, 32'h0,         5'd6,  32'h1280_FF00, 1'b1, 4'b0000, 32'h0,         32'h0000_0080, 2'b00, 1'b1, 3};
      vec[6]  = '{LD, 3'b101, 32'h0000_2002, 32'h0,         5'd7,  32'h1280_FF00, 1'b1, 4'b0000, 32'h0,         32'h0000_1280, 2'b00, 1'b1, 3};
      vec[7]  = '{LD, 3'b001, 32'h0000_2000, 32'h0,         5'd8,  32'h1280_FF00, 1'b1, 4'b0000, 32'h0,         32'hFFFF_FF00, 2'b00, 1'b1, 3};
      vec[8]  = '{LD, 3'b010, 32'h0000_2004, 32'h0,         5'd9,  32'h1280_FF00, 1'b1, 4'b0000, 32'h0,         32'h1280_FF00, 2'b00, 1'b1, 3};
      vec[9]  = '{LD, 3'b000, 32'h0000_2001, 32'h0,         5'd10, 32'h1280_FF00, 1'b1, 4'b0000, 32'h0,         32'hFFFF_FFFF, 2'b00, 1'b1, 3};
      vec[10] = '{LD, 3'b100, 32'h0000_2003, 32'h0,         5'd11, 32'h1280_FF00, 1'b1, 4'b0000, 32'h0,         32'h0000_0012, 2'b00, 1'b1, 3};
      vec[11] = '{LD, 3'b010, 32'h0000_2001, 32'h0,         5'd12, 32'h1280_FF00, 1'b0, 4'b0000, 32'h0,         32'h0,         2'b01, 1'b0, 1};
      vec[12] = '{LD, 3'b001, 32'h0000_2003, 32'h0,         5'd13, 32'h1280_FF00, 1'b0, 4'b0000, 32'h0,         32'h0,         2'b01, 1'b0, 1};
      vec[13] = '{LD, 3'b110, 32'h0000_2000, 32'h0,         5'd14, 32'h1280_FF00, 1'b0, 4'b0000, 32'h0,         32'h0,         2'b01, 1'b0, 1};
      vec[14] = '{ST, 3'b010, 32'h0000_1002, 32'h1111_2222, 5'd15, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         2'b01, 1'b0, 1};
      vec[15] = '{ST, 3'b011, 32'h0000_1000, 32'h1111_2222, 5'd16, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         2'b01, 1'b0, 1};
      vec[16] = '{7'b0110011, 3'b000, 32'h0, 32'h0,         5'd17, 32'h0,         1'b0, 4'b0000, 32'h0,         32'h0,         2'b01, 1'b0, 1};

      rst_n = 1'b0; in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_addr = '0;
      in_wdata = '0; in_rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      #12;
      chk("reset in_ready",  32'(in_ready), 32'd1);
      chk("reset mem_req",   32'(mem_req), 32'd0);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset mem_addr",  mem_addr, 32'h0);
      chk("reset mem_wstrb", 32'(mem_wstrb), 32'h0);
      chk("reset out_data",  out_data, 32'h0);
      chk("reset out_err",   32'(out_err), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();

      // Table vectors against a zero-wait memory: gnt on first mem_req cycle, rvalid the next cycle
      for (int v = 0; v < NV; v++) begin
         int  cyc;
         bit  got, saw_req, gnt_prev;
         chk($sformatf("in_ready v%0d", v), 32'(in_ready), 32'd1);
         mem_rdata = vec[v].rdata;
         issue(vec[v].op, vec[v].f3, vec[v].addr, vec[v].wdata, vec[v].rd);
         cyc = 1; got = 0; saw_req = 0; gnt_prev = 0;
         while (cyc <= 8 && !got) begin
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (mem_req && !saw_req) begin
               saw_req = 1;
               chk($sformatf("mem_addr v%0d", v), mem_addr, {vec[v].addr[31:2], 2'b00});
               chk($sformatf("mem_we v%0d", v), 32'(mem_we), 32'(vec[v].op == ST));
               if (vec[v].op == ST) begin
                  chk($sformatf("mem_wstrb v%0d", v), 32'(mem_wstrb), 32'(vec[v].e_wstrb));
                  chk($sformatf("mem_wdata v%0d", v), mem_wdata, vec[v].e_wdata);
               end
               mem_gnt = 1'b1;
            end
            if (gnt_prev && vec[v].op == LD) mem_rvalid = 1'b1;
            gnt_prev = mem_gnt;
            if (out_valid) begin
               got = 1;
               chk($sformatf("latency v%0d", v), 32'(cyc), 32'(vec[v].e_lat));
               chk($sformatf("out_data v%0d", v), out_data, vec[v].e_data);
               chk($sformatf("out_err v%0d", v), 32'(out_err), 32'(vec[v].e_err));
               chk($sformatf("out_we v%0d", v), 32'(out_we), 32'(vec[v].e_we));
               chk($sformatf("out_rd v%0d", v), 32'(out_rd), 32'(vec[v].rd));
            end else begin
               tick();
               cyc++;
            end
         end
         chk($sformatf("completed v%0d", v), 32'(got), 32'd1);
         chk($sformatf("mem_req seen v%0d", v), 32'(saw_req), 32'(vec[v].e_req));
         mem_gnt = 1'b0;
         mem_rvalid = 1'b0;
         tick();
         chk($sformatf("pulse end v%0d", v), 32'(out_valid), 32'd0);
      end

      // Timeout: gnt never arrives
      issue(LD, 3'b010, 32'h0000_3000, 32'h0, 5'd4);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("tmo mem_req c%0d", i), 32'(mem_req), 32'd1);
         chk($sformatf("tmo out_valid c%0d", i), 32'(out_valid), 32'd0);
         tick();
      end
      chk("tmo mem_req drop", 32'(mem_req), 32'd0);
      chk("tmo out_valid", 32'(out_valid), 32'd1);
      chk("tmo out_err", 32'(out_err), 32'd2);
      chk("tmo out_we", 32'(out_we), 32'd0);
      tick();

      // Wait states: gnt after 3 idle cycles, early rvalid ignored, rvalid 2 cycles after gnt
      issue(LD, 3'b001, 32'h0000_4002, 32'h0, 5'd9);
      for (int i = 1; i <= 3; i++) begin
         chk($sformatf("wait mem_req c%0d", i), 32'(mem_req), 32'd1);
         chk($sformatf("wait mem_addr c%0d", i), mem_addr, 32'h0000_4000);
         chk($sformatf("wait out_valid c%0d", i), 32'(out_valid), 32'd0);
         mem_rvalid = (i == 2);
         mem_rdata  = 32'hFFFF_FFFF;
         tick();
      end
      mem_rvalid = 1'b0;
      chk("wait mem_req c4", 32'(mem_req), 32'd1);
      chk("wait mem_we c4", 32'(mem_we), 32'd0);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("wait mem_req after gnt", 32'(mem_req), 32'd0);
      chk("wait out_valid c5", 32'(out_valid), 32'd0);
      tick();
      chk("wait out_valid c6", 32'(out_valid), 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h8001_0000;
      tick();
      mem_rvalid = 1'b0;
      chk("wait out_valid", 32'(out_valid), 32'd1);
      chk("wait out_data", out_data, 32'hFFFF_8001);
      chk("wait out_we", 32'(out_we), 32'd1);
      chk("wait out_err", 32'(out_err), 32'd0);
      chk("wait out_rd", 32'(out_rd), 32'd9);
      tick();

      // Reset during REQ: mem_req drops without a clock edge; late responses are ignored
      issue(LD, 3'b010, 32'h0000_5000, 32'h0, 5'd3);
      chk("rst pre mem_req", 32'(mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst mem_req", 32'(mem_req), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      tick();
      rst_n = 1'b1;
      mem_gnt = 1'b1;
      mem_rvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("rst late out_valid c%0d", i), 32'(out_valid), 32'd0);
         chk($sformatf("rst late mem_req c%0d", i), 32'(mem_req), 32'd0);
      end
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-side end of the ALU address path for RV32I loads and stores. Takes the effective address the ALU computes for LOAD (0000011) and STORE (0100011) opcodes, plus store data and funct3. Drives a word-oriented data-memory request/grant/response bus, and returns write-back data (byte/half extracted, sign- or zero-extended) to the pipeline. Sits between execute and write-back; the pipeline stalls while in_ready is low.

Parameters:
TIMEOUT, 255, max cycles waiting for mem_gnt or mem_rvalid before a bus error; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation offered by execute
in_ready  out  1  unit idle, can accept
in_opcode  in  7  0000011 load, 0100011 store; other values are illegal
in_funct3  in  3  access size/sign
in_addr  in  32  effective address from ALU
in_wdata  in  32  store data (rs2)
in_rd  in  5  destination register tag
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  32  word address, {in_addr[31:2],2'b00}
mem_wstrb  out  4  byte enables for writes
mem_wdata  out  32  lane-shifted store data
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word
out_valid  out  1  one-cycle completion pulse
out_we  out  1  write-back enable (load success only)
out_rd  out  5  destination tag
out_data  out  32  extended load data
out_err  out  2  00 ok, 01 misaligned/illegal, 10 bus timeout

Behaviour:
- Reset (async, immediate): state IDLE. in_ready=1. mem_req, mem_we, out_valid and out_we are 0. mem_addr, mem_wstrb, mem_wdata, out_rd, out_data and out_err are 0. Wait counter is 0.
- All outputs are registered; in_ready = (state==IDLE).
- States: IDLE, REQ, RESP, DONE.
- IDLE: accept on in_valid&in_ready at cycle T. Latch opcode, funct3, addr[1:0] and rd.
  - Illegal opcode, illegal funct3, or misalignment -> DONE with out_err=01 and no memory access.
    - Illegal funct3 for loads: 011, 110, 111. Illegal funct3 for stores: >=011.
    - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
  - Otherwise -> REQ, with mem_req=1 from T+1.
- REQ: mem_req, mem_we, mem_addr, mem_wstrb and mem_wdata are held stable until mem_gnt.
  - On gnt: drop mem_req. Store -> DONE. Load -> RESP.
- RESP: mem_rvalid is sampled only here, i.e. at least 1 cycle after gnt; rvalid during REQ is ignored. On rvalid -> DONE with extracted data.
- DONE: out_valid=1 for exactly one cycle, then IDLE.
  - out_we=1 only for a load with err=00.
  - out_data=0 for stores and errors.
- Latency (zero-wait memory): error completes at T+1; store at T+2; load at T+3. The next accept is possible the cycle after out_valid.
- Store lanes, b=addr[1:0]:
  - SB: wstrb=0001<<b; wdata = {4{wdata[7:0]}}.
  - SH: wstrb=0011<<b; wdata = {2{wdata[15:0]}}.
  - SW: wstrb=1111; wdata = in_wdata.
- Load extraction: byte = rdata[8b+7:8b]; half = rdata[8b+15:8b].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Timeout: the counter clears on entry to REQ and again on gnt, and increments each cycle in REQ/RESP. When TIMEOUT!=0 and counter==TIMEOUT-1 with no gnt/rvalid -> drop mem_req, go to DONE with err=10, out_we=0.
- Reset mid-operation: mem_req drops asynchronously and the transaction is abandoned. A late gnt/rvalid after reset is ignored because the unit is in IDLE.
- in_valid while busy: no effect (in_ready=0); the upstream stage holds its operands.

Test Plan:
- SW addr=0x1000 wdata=0xDEADBEEF, gnt at T+1 -> mem_req at T+1, mem_we=1, wstrb=1111, mem_addr=0x1000; out_valid at T+2, out_we=0, err=00.
- SB addr=0x1003 wdata=0x000000A5 -> wstrb=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x1000.
- LB addr=0x2002, rdata=0x1280FF00, rvalid at T+2 -> out_data=0xFFFFFF80 at T+3, out_we=1, rd echoed. Same with LBU -> 0x00000080. LHU addr=0x2002 -> 0x00001280.
- LW addr=0x2001 -> no mem_req; out_valid at T+1, err=01, out_we=0. LH addr=0x2003 -> err=01. Load funct3=110 -> err=01.
- TIMEOUT=4, load, mem_gnt held low -> mem_req high for 4 cycles then low; out_valid with err=10.
- Load with gnt after 3 wait cycles, rvalid after 2 more -> data correct, mem_req stable throughout. Then assert rst_n=0 during REQ -> mem_req=0 immediately, in_ready=1; a later rvalid produces no out_valid.
